// File: rtl/hard_mem_1rw_bit_mask_tiled_wrapper.sv
// Bit-masked 1rw memory of width_p x els_p built from tsmc65lp_1rf_lg6_w16_bit tiles.
// Define MEM_ZERO_INIT_EN to zero the whole array after reset before accepting requests.

module tsmc65lp_1rf_lg6_w16_bit (
  input  logic        CLK,
  input  logic        CEN,
  input  logic        GWEN,
  input  logic [15:0] WEN,
  input  logic [5:0]  A,
  input  logic [15:0] D,
  input  logic [2:0]  EMA,
  input  logic [1:0]  EMAW,
  input  logic        RET1N,
  output logic [15:0] Q
);
  logic [15:0] mem [64];
  logic        unused_margin;

  assign unused_margin = ^{EMA, EMAW, RET1N};

  // Q only updates on reads; writes leave the last read word on Q
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      else       Q      <= mem[A];
    end
  end
endmodule

// state | meaning
// INIT  | zeroing sweep over macro addresses 0..63, requests refused
// READY | accepting requests
module hard_mem_1rw_bit_mask_tiled_wrapper #(
  parameter  int width_p       = 15,
  parameter  int els_p         = 64,
  parameter  int macro_width_p = 16,
  parameter  int macro_els_p   = 64,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int cols_lp       = (width_p + macro_width_p - 1) / macro_width_p,
  localparam int rows_lp       = (els_p + macro_els_p - 1) / macro_els_p
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,
  output logic                     ready_o,
  output logic [width_p-1:0]       data_o,
  output logic                     data_v_o
);
  localparam int maddr_width_lp = 6;
  localparam int row_width_lp   = (addr_width_lp > maddr_width_lp) ? addr_width_lp - maddr_width_lp : 1;
  localparam int pad_width_lp   = cols_lp * macro_width_p;
  localparam logic [addr_width_lp:0] els_lp = (addr_width_lp + 1)'(els_p);

  logic                      accept;
  logic                      ready_q;
  logic                      init_active;
  logic [maddr_width_lp-1:0] init_addr;
  logic [maddr_width_lp-1:0] macro_addr;
  logic [row_width_lp-1:0]   row;
  logic [row_width_lp-1:0]   row_q;
  logic [rows_lp-1:0]        row_cen_n;
  logic                      gwen_n;
  logic [maddr_width_lp-1:0] mem_addr;
  logic [pad_width_lp-1:0]   mem_d;
  logic [pad_width_lp-1:0]   wen_n;
  logic [pad_width_lp-1:0]   q_row [rows_lp];
  logic [pad_width_lp-1:0]   q_sel;
  logic                      unused_q_pad;
  logic                      rd_v_q;
  logic [width_p-1:0]        hold_q;

  assign ready_o = ready_q;
  assign accept  = v_i & ready_q;

`ifdef MEM_ZERO_INIT_EN
  typedef enum logic {INIT, READY} state_e;
  state_e                    state_q;
  logic [maddr_width_lp-1:0] init_addr_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= INIT;
      init_addr_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          init_addr_q <= init_addr_q + 1'b1;
          if (init_addr_q == 6'd63) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        default: ready_q <= 1'b1;
      endcase
    end
  end

  // gated by reset so no macro is enabled while reset is held
  assign init_active = (state_q == INIT) & reset_n_i;
  assign init_addr   = init_addr_q;
`else
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ready_q <= 1'b0;
    else            ready_q <= 1'b1;
  end

  assign init_active = 1'b0;
  assign init_addr   = '0;
`endif

  if (addr_width_lp > maddr_width_lp) begin : g_split
    assign row        = addr_i[addr_width_lp-1:maddr_width_lp];
    assign macro_addr = addr_i[maddr_width_lp-1:0];
  end else begin : g_no_split
    assign row        = '0;
    assign macro_addr = maddr_width_lp'(addr_i);
  end

  // zero-extended mask leaves the top column's pad bits with WEN=1
  assign gwen_n   = init_active ? 1'b0 : ~w_i;
  assign wen_n    = init_active ? '0 : ~pad_width_lp'(w_mask_i);
  assign mem_d    = init_active ? '0 : pad_width_lp'(data_i);
  assign mem_addr = init_active ? init_addr : macro_addr;

  for (genvar r = 0; r < rows_lp; r++) begin : g_tile_row
    assign row_cen_n[r] = ~(init_active | (accept & (row == row_width_lp'(r))));
    for (genvar c = 0; c < cols_lp; c++) begin : g_tile_col
      tsmc65lp_1rf_lg6_w16_bit macro (
        .CLK   (clk_i),
        .CEN   (row_cen_n[r]),
        .GWEN  (gwen_n),
        .WEN   (wen_n[c*macro_width_p +: macro_width_p]),
        .A     (mem_addr),
        .D     (mem_d[c*macro_width_p +: macro_width_p]),
        .EMA   (3'd3),
        .EMAW  (2'd1),
        .RET1N (1'b1),
        .Q     (q_row[r][c*macro_width_p +: macro_width_p])
      );
    end
  end

  always_comb begin
    q_sel = '0;
    for (int r = 0; r < rows_lp; r++) begin
      if (row_q == row_width_lp'(r)) q_sel = q_row[r];
    end
  end

  assign unused_q_pad = ^q_sel;
  assign data_o       = rd_v_q ? q_sel[width_p-1:0] : hold_q;
  assign data_v_o     = rd_v_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_v_q <= 1'b0;
      row_q  <= '0;
      hold_q <= '0;
    end else begin
      rd_v_q <= accept & ~w_i;
      if (accept & ~w_i) row_q <= row;
      if (rd_v_q) hold_q <= data_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && accept) assert ({1'b0, addr_i} < els_lp);
  end
endmodule

// File: tb/tb_hard_mem_1rw_bit_mask_tiled_wrapper.sv
// Bench for the tiled bit-masked memory wrapper: a 15x64 instance with directed checks and
// a 40x200 instance (3 columns, 4 rows) checked every cycle against an array model.
`timescale 1ns/1ps
module tb_hard_mem_1rw_bit_mask_tiled_wrapper;
`ifdef MEM_ZERO_INIT_EN
  localparam int init_cycles = 64;
`else
  localparam int init_cycles = 1;
`endif
  localparam int eb = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_v = 1'b0, a_w = 1'b0;
  logic [5:0]  a_addr = '0;
  logic [14:0] a_data = '0, a_mask = '0;
  logic        a_ready, a_dv;
  logic [14:0] a_dout;

  logic        b_v = 1'b0, b_w = 1'b0;
  logic [7:0]  b_addr = '0;
  logic [39:0] b_data = '0, b_mask = '0;
  logic        b_ready, b_dv;
  logic [39:0] b_dout;

  hard_mem_1rw_bit_mask_tiled_wrapper #(.width_p(15), .els_p(64)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(a_v), .w_i(a_w), .addr_i(a_addr),
    .data_i(a_data), .w_mask_i(a_mask), .ready_o(a_ready), .data_o(a_dout), .data_v_o(a_dv));

  hard_mem_1rw_bit_mask_tiled_wrapper #(.width_p(40), .els_p(eb)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(b_v), .w_i(b_w), .addr_i(b_addr),
    .data_i(b_data), .w_mask_i(b_mask), .ready_o(b_ready), .data_o(b_dout), .data_v_o(b_dv));

  int n_vec = 0, n_err = 0;
  bit chk_en = 1'b0;

  logic [39:0] mem_m [eb];
  logic [39:0] exp_d = '0;
  logic        exp_v = 1'b0, exp_ready = 1'b0, acc_m;
  int          rdy_cnt = init_cycles;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model of the 40x200 instance: a word array plus the last value read out
  always @(posedge clk) begin
    if (rst_n) begin
      acc_m = b_v && exp_ready;
      if (acc_m && !b_w) begin
        exp_v = 1'b1;
        exp_d = mem_m[b_addr];
      end else begin
        exp_v = 1'b0;
      end
      if (acc_m && b_w) mem_m[b_addr] = (mem_m[b_addr] & ~b_mask) | (b_data & b_mask);
      if (rdy_cnt > 0) rdy_cnt--;
      exp_ready = (rdy_cnt == 0);
    end
  end

  always @(negedge rst_n) begin
    exp_v     = 1'b0;
    exp_d     = '0;
    exp_ready = 1'b0;
    rdy_cnt   = init_cycles;
`ifdef MEM_ZERO_INIT_EN
    for (int i = 0; i < eb; i++) mem_m[i] = '0;
`endif
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("b_ready", 64'(b_ready), 64'(exp_ready));
      check("b_data_v", 64'(b_dv), 64'(exp_v));
      check("b_data", 64'(b_dout), 64'(exp_d));
    end
  end

  task automatic set_a(input logic w, input logic [5:0] addr, input logic [14:0] d, input logic [14:0] m);
    a_v = 1'b1; a_w = w; a_addr = addr; a_data = d; a_mask = m;
  endtask

  task automatic set_b(input logic w, input logic [7:0] addr, input logic [39:0] d, input logic [39:0] m);
    b_v = 1'b1; b_w = w; b_addr = addr; b_data = d; b_mask = m;
  endtask

  task automatic tick();
    @(negedge clk);
    a_v = 1'b0;
    b_v = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 200 && !b_ready; i++) tick();
    check(name, 64'(b_ready & a_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] r64;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("a_reset_ready", 64'(a_ready), 64'd0);
    check("a_reset_data_v", 64'(a_dv), 64'd0);
    check("a_reset_data", 64'(a_dout), 64'd0);
    rst_n = 1'b1;
    tick();
    wait_ready("ready_after_reset");

    for (int i = 0; i < eb; i++) begin
      r64 = {$urandom, $urandom};
      set_b(1'b1, 8'(i), r64[39:0], '1);
      tick();
    end

    // 15x64 instance: full write, masked write, hold
    set_a(1'b1, 6'd5, 15'h7FFF, 15'h7FFF);
    tick();
    check("a_write_no_data_v", 64'(a_dv), 64'd0);
    set_a(1'b0, 6'd5, '0, '0);
    tick();
    check("a_read_data_v", 64'(a_dv), 64'd1);
    check("a_read_full", 64'(a_dout), 64'h7FFF);
    set_a(1'b1, 6'd5, 15'h0000, 15'h00FF);
    tick();
    check("a_write_keeps_data", 64'(a_dout), 64'h7FFF);
    set_a(1'b0, 6'd5, '0, '0);
    tick();
    check("a_read_masked", 64'(a_dout), 64'h7F00);
    tick();
    check("a_idle_data_v", 64'(a_dv), 64'd0);
    check("a_idle_hold", 64'(a_dout), 64'h7F00);

    // 40x200 instance: tiled rows/columns, back-to-back reads, row enables
    set_b(1'b1, 8'd3, 40'hAA_5555_AAAA, '1);
    tick();
    set_b(1'b1, 8'd131, 40'h11_2233_4455, '1);
    tick();
    set_b(1'b0, 8'd131, '0, '0);
    #1 check("b_cen_row2", 64'(dut_b.row_cen_n), 64'b1011);
    tick();
    check("b_read_131", 64'(b_dout), 64'h11_2233_4455);
    set_b(1'b0, 8'd3, '0, '0);
    #1 check("b_cen_row0", 64'(dut_b.row_cen_n), 64'b1110);
    tick();
    check("b_read_3", 64'(b_dout), 64'hAA_5555_AAAA);
    check("b_read_3_data_v", 64'(b_dv), 64'd1);
    tick();
    check("b_idle_cen", 64'(dut_b.row_cen_n), 64'b1111);

    set_b(1'b0, 8'd3, '0, '0);
    tick();
    set_b(1'b1, 8'd3, 40'h01_2345_6789, '1);
    tick();
    repeat (5) tick();
    check("b_hold_after_write", 64'(b_dout), 64'hAA_5555_AAAA);
    check("b_hold_data_v", 64'(b_dv), 64'd0);
    set_b(1'b1, 8'd3, 40'h0, 40'hFF_0000_00FF);
    tick();
    set_b(1'b0, 8'd3, '0, '0);
    tick();
    check("b_raw_masked", 64'(b_dout), 64'h00_2345_6700);

    for (int i = 0; i < 2000; i++) begin
      r64 = {$urandom, $urandom};
      if ($urandom_range(0, 9) < 7) begin
        set_b(1'($urandom_range(0, 1)), 8'($urandom_range(0, eb - 1)), r64[39:0],
              {r64[7:0], $urandom});
      end
      tick();
    end

    // async reset in the middle of a read, then a request that must be dropped
    set_b(1'b0, 8'd10, '0, '0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_data", 64'(b_dout), 64'd0);
    check("rst_async_data_v", 64'(b_dv), 64'd0);
    check("rst_async_ready", 64'(b_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_b(1'b1, 8'd10, ~mem_m[10], '1);
    tick();
    wait_ready("ready_after_mid_reset");
    set_b(1'b0, 8'd10, '0, '0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
